mem_port_arb: RTL and testbench

- Sequences the single-port synchronous data/instruction RAM and shares it between instruction fetch (IF) and load/store (LS).
- LS has priority because it belongs to the older instruction; a starvation limiter guarantees fetch progress.
- Performs byte-lane steering, sign/zero extension and misalignment detection for LS.
- Drives a stall signal to ctrl, which replaces ctrl's two-cycle load_phase sequencing.

---
 rtl/mem_arb_pkg.sv | 49 ++++
 rtl/mem_port_arb_ls_align.sv | 46 ++++
 rtl/mem_port_arb.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory port arbiter.
//   arb_state_e  : outstanding-return tracking state of mem_port_arb.
//   FUNC3_*      : load/store width encodings.
//   be_gen       : store byte-enable pattern for a width and byte offset.
//   is_misaligned: alignment check for a width and byte offset.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F_RD  = 3'd1,
        D_RD  = 3'd2,
        D_WR  = 3'd3,
        D_ERR = 3'd4
    } arb_state_e;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_SB  = 3'b000;
    localparam logic [2:0] FUNC3_SH  = 3'b001;
    localparam logic [2:0] FUNC3_SW  = 3'b010;

    // Width is carried by func3[1:0]; 2'b11 (and therefore 011/111) falls
    // through to word, as does 110.
    function automatic logic [3:0] be_gen(input logic [2:0] func3,
                                          input logic [1:0] addr_lo);
        logic [3:0] be;
        case (func3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] func3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (func3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_port_arb_ls_align.sv
// ls_align: combinational byte-lane handling for the load/store port.
//   st_func3_i, st_wdata_i   -> st_wdata_o  : store data replicated to all lanes
//   ld_func3_i, ld_addr_lo_i,
//   ld_rdata_i               -> ld_data_o   : selected lane, sign/zero extended
module ls_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  st_func3_i,
    input  logic [31:0] st_wdata_i,
    input  logic [2:0]  ld_func3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] st_wdata_o,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sext;
    logic        unused_st_func3;

    assign unused_st_func3 = st_func3_i[2];

    assign ld_shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
    assign ld_byte    = ld_shifted[7:0];
    assign ld_half    = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    assign ld_sext    = ~ld_func3_i[2];

    always_comb begin
        case (st_func3_i[1:0])
            2'b00:   st_wdata_o = {4{st_wdata_i[7:0]}};
            2'b01:   st_wdata_o = {2{st_wdata_i[15:0]}};
            default: st_wdata_o = st_wdata_i;
        endcase
    end

    always_comb begin
        case (ld_func3_i[1:0])
            2'b00:   ld_data_o = {{24{ld_sext & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data_o = {{16{ld_sext & ld_half[15]}}, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares a single-port synchronous RAM between instruction
// fetch (IF) and load/store (LS). LS wins unless it has starved IF for
// STARVE_LIM consecutive grants. One access per cycle; read data returns
// the cycle after the grant and is presented with a registered valid.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   if_req/if_addr            fetch request; if_gnt, if_valid, if_rdata
//   ls_req/ls_we/ls_func3/
//   ls_addr/ls_wdata          load/store request; ls_gnt, ls_valid,
//                             ls_err, ls_rdata
//   stall                     LS request not granted this cycle
//   mem_en/we/be/addr/wdata   RAM strobe side; mem_rdata read return
//
// Optional (MEM_ARB_STATS_EN): stat_clr, stat_if_cnt, stat_ls_cnt,
// stat_conf_cnt saturating 16-bit grant/conflict counters.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MEM_ARB_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_if_cnt,
    output logic [15:0]       stat_ls_cnt,
    output logic [15:0]       stat_conf_cnt,
`endif
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_func3,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic              ls_err,
    output logic [31:0]       ls_rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);

    arb_state_e  state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [2:0]  ld_func3_q;
    logic [1:0]  ld_addr_lo_q;
    logic        if_valid_q, ls_valid_q, ls_err_q;
    logic        ls_mis;
    logic [31:0] st_wdata_rep;
    logic [31:0] ld_data;
    logic        unused_if_addr;

    assign unused_if_addr = ^if_addr[1:0];

    // Grants are forced low during reset even though the request inputs
    // may already be active.
    assign ls_mis = is_misaligned(ls_func3, ls_addr[1:0]);
    assign ls_gnt = ~rst & ls_req & (~if_req | (starve_cnt_q < STARVE_LIM_C));
    assign if_gnt = ~rst & if_req & ~ls_gnt;
    assign stall  = ls_req & ~ls_gnt;

    // A misaligned access is granted (to retire with an error) but never
    // reaches the RAM.
    assign mem_en    = if_gnt | (ls_gnt & ~ls_mis);
    assign mem_we    = ls_gnt & ls_we & ~ls_mis;
    assign mem_be    = !mem_en ? 4'b0000 :
                       mem_we  ? be_gen(ls_func3, ls_addr[1:0]) : 4'b1111;
    assign mem_addr  = ls_gnt ? ls_addr[ADDR_W-1:2] :
                       if_gnt ? if_addr[ADDR_W-1:2] : '0;
    assign mem_wdata = st_wdata_rep;

    ls_align u_ls_align (
        .st_func3_i   (ls_func3),
        .st_wdata_i   (ls_wdata),
        .ld_func3_i   (ld_func3_q),
        .ld_addr_lo_i (ld_addr_lo_q),
        .ld_rdata_i   (mem_rdata),
        .st_wdata_o   (st_wdata_rep),
        .ld_data_o    (ld_data)
    );

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt || !if_req) begin
            starve_cnt_d = '0;
        end else if (ls_gnt && (starve_cnt_q < STARVE_LIM_C)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (ls_gnt) begin
            if (ls_mis)     state_d = D_ERR;
            else if (ls_we) state_d = D_WR;
            else            state_d = D_RD;
        end else if (if_gnt) begin
            state_d = F_RD;
        end
    end

    // The state records which return is due next cycle; valid flags are
    // registered alongside it so they leave the block straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            ld_func3_q   <= '0;
            ld_addr_lo_q <= '0;
            if_valid_q   <= 1'b0;
            ls_valid_q   <= 1'b0;
            ls_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if_valid_q   <= (state_d == F_RD);
            ls_valid_q   <= (state_d == D_RD) || (state_d == D_WR) || (state_d == D_ERR);
            ls_err_q     <= (state_d == D_ERR);
            if (ls_gnt && !ls_we) begin
                ld_func3_q   <= ls_func3;
                ld_addr_lo_q <= ls_addr[1:0];
            end
        end
    end

    assign if_valid = if_valid_q;
    assign ls_valid = ls_valid_q;
    assign ls_err   = ls_err_q;
    assign if_rdata = (state_q == F_RD) ? mem_rdata : '0;
    assign ls_rdata = (state_q == D_RD) ? ld_data : '0;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_if_q, stat_ls_q, stat_conf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_if_q   <= '0;
            stat_ls_q   <= '0;
            stat_conf_q <= '0;
        end else if (stat_clr) begin
            stat_if_q   <= '0;
            stat_ls_q   <= '0;
            stat_conf_q <= '0;
        end else begin
            if (if_gnt && (stat_if_q != 16'hFFFF))           stat_if_q   <= stat_if_q + 16'd1;
            if (ls_gnt && (stat_ls_q != 16'hFFFF))           stat_ls_q   <= stat_ls_q + 16'd1;
            if (if_req && ls_req && (stat_conf_q != 16'hFFFF)) stat_conf_q <= stat_conf_q + 16'd1;
        end
    end

    assign stat_if_cnt   = stat_if_q;
    assign stat_ls_cnt   = stat_ls_q;
    assign stat_conf_cnt = stat_conf_q;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
module tb_mem_port_arb;

    localparam int LIM = 4;
    localparam int AW  = 32;

    logic          clk, rst;
    logic          if_req, if_gnt, if_valid;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_valid, ls_err;
    logic [2:0]    ls_func3;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata, ls_rdata;
    logic          stall, mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_if_cnt, stat_ls_cnt, stat_conf_cnt;
    initial stat_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arb #(.STARVE_LIM(LIM), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
`ifdef MEM_ARB_STATS_EN
        .stat_clr(stat_clr), .stat_if_cnt(stat_if_cnt),
        .stat_ls_cnt(stat_ls_cnt), .stat_conf_cnt(stat_conf_cnt),
`endif
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_func3(ls_func3),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_valid(ls_valid), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Environment RAM: synchronous read, byte-enabled write.
    logic [31:0] ram [0:255];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h04] = 32'h1111_2222;
        ram[8'h05] = 32'h5555_AAAA;
        ram[8'h08] = 32'hDEAD_0008;
        ram[8'h40] = 32'h80FF_FF12;
        ram[8'h80] = 32'h1234_5678;
        mem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) ram[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else begin
                    mem_rdata <= ram[mem_addr[7:0]];
                end
            end
        end
    end

    // Reference model: kinds of pending return 0 none, 1 fetch, 2 load,
    // 3 store ack, 4 error.
    int          m_starve = 0;
    int          m_kind   = 0;
    logic [31:0] m_data   = 0;

    always @(negedge clk) begin
        int          size;
        bit          uns, mis, e_ls, e_if, e_en, e_we;
        logic [31:0] word, mask, v, be;
        int          sh;
        if (rst) begin
            chk("rst_if_gnt", {31'b0, if_gnt}, 0);
            chk("rst_ls_gnt", {31'b0, ls_gnt}, 0);
            chk("rst_mem_en", {31'b0, mem_en}, 0);
            chk("rst_mem_we", {31'b0, mem_we}, 0);
            chk("rst_if_valid", {31'b0, if_valid}, 0);
            chk("rst_ls_valid", {31'b0, ls_valid}, 0);
            chk("rst_ls_err", {31'b0, ls_err}, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_ls_rdata", ls_rdata, 0);
            chk("rst_stall", {31'b0, stall}, {31'b0, ls_req});
            m_starve = 0;
            m_kind   = 0;
        end else begin
            chk("if_valid", {31'b0, if_valid}, {31'b0, m_kind == 1});
            chk("ls_valid", {31'b0, ls_valid}, {31'b0, m_kind >= 2});
            chk("ls_err", {31'b0, ls_err}, {31'b0, m_kind == 4});
            if (m_kind == 1) chk("if_rdata", if_rdata, m_data);
            if (m_kind == 2) chk("ls_rdata", ls_rdata, m_data);

            case (ls_func3)
                3'b000, 3'b100: size = 1;
                3'b001, 3'b101: size = 2;
                default:        size = 4;
            endcase
            uns  = (ls_func3 == 3'b100) || (ls_func3 == 3'b101);
            mis  = (ls_addr % size) != 0;
            e_ls = ls_req && (!if_req || m_starve < LIM);
            e_if = if_req && !e_ls;
            e_en = e_if || (e_ls && !mis);
            e_we = e_ls && ls_we && !mis;
            chk("ls_gnt", {31'b0, ls_gnt}, {31'b0, e_ls});
            chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_if});
            chk("stall", {31'b0, stall}, {31'b0, ls_req && !e_ls});
            chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
            chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            if (e_en) begin
                chk("mem_addr", {2'b0, mem_addr}, (e_ls ? ls_addr : if_addr) / 4);
                be = (size == 4) ? 32'hF : ((32'd1 << size) - 1) << (ls_addr % 4);
                chk("mem_be", {28'b0, mem_be}, e_we ? be : 32'hF);
            end
            if (e_we) begin
                if (size == 1)      v = {4{ls_wdata[7:0]}};
                else if (size == 2) v = {2{ls_wdata[15:0]}};
                else                v = ls_wdata;
                chk("mem_wdata", mem_wdata, v);
            end

            if (e_ls) begin
                if (mis)        m_kind = 4;
                else if (ls_we) m_kind = 3;
                else begin
                    m_kind = 2;
                    word = ram[(ls_addr / 4) % 256];
                    if (size == 4) v = word;
                    else begin
                        sh   = (ls_addr % 4) * 8;
                        mask = (32'd1 << (8 * size)) - 1;
                        v    = (word >> sh) & mask;
                        if (!uns && v[8*size-1]) v = v | ~mask;
                    end
                    m_data = v;
                end
            end else if (e_if) begin
                m_kind = 1;
                m_data = ram[(if_addr / 4) % 256];
            end else begin
                m_kind = 0;
            end

            if (e_if || !if_req)                   m_starve = 0;
            else if (e_ls && m_starve < LIM)       m_starve = m_starve + 1;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // One LS transaction followed by an idle cycle carrying its return.
    task automatic ls_op(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
        ls_req = 1'b1; ls_we = we; ls_func3 = f3; ls_addr = addr; ls_wdata = wd;
        @(negedge clk);
        chk({name, "_gnt"}, {31'b0, ls_gnt}, 1);
        chk({name, "_en"}, {31'b0, mem_en}, {31'b0, !exp_err});
        if (we && !exp_err) begin
            chk({name, "_we"}, {31'b0, mem_we}, 1);
            chk({name, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
            chk({name, "_wdata"}, mem_wdata, exp_wd);
        end
        next_cyc();
        ls_req = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, {31'b0, ls_valid}, 1);
        chk({name, "_err"}, {31'b0, ls_err}, {31'b0, exp_err});
        if (!we && !exp_err) chk({name, "_rdata"}, ls_rdata, exp_rd);
        next_cyc();
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_func3 = 0; ls_addr = 0; ls_wdata = 0;
        @(negedge clk);
        chk("reset_if_valid", {31'b0, if_valid}, 0);
        next_cyc();
        rst = 1'b0;
        next_cyc();

        // Single fetch.
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        chk("fetch_gnt", {31'b0, if_gnt}, 1);
        chk("fetch_maddr", {2'b0, mem_addr}, 32'h4);
        next_cyc();
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_valid", {31'b0, if_valid}, 1);
        chk("fetch_rdata", if_rdata, 32'h1111_2222);
        next_cyc();

        // Starvation limiter: LS wins four times, fifth cycle goes to IF.
        if_req = 1'b1; if_addr = 32'h14;
        ls_req = 1'b1; ls_we = 1'b0; ls_func3 = 3'b010; ls_addr = 32'h20;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("starve_c1_ls", {31'b0, ls_gnt}, 1);
                chk("starve_c1_if", {31'b0, if_gnt}, 0);
            end
            if (c == 5) begin
                chk("starve_c5_if", {31'b0, if_gnt}, 1);
                chk("starve_c5_ls", {31'b0, ls_gnt}, 0);
                chk("starve_c5_stall", {31'b0, stall}, 1);
            end
            next_cyc();
        end
        if_req = 1'b0;
        @(negedge clk);
        chk("starve_after_ls", {31'b0, ls_gnt}, 1);
        chk("starve_if_rdata", if_rdata, 32'h5555_AAAA);
        next_cyc();
        ls_req = 1'b0;
        @(negedge clk);
        chk("starve_ls_rdata", ls_rdata, 32'hDEAD_0008);
        next_cyc();

        ls_op("lb",     0, 3'b000, 32'h103, 0,            0, 32'hFFFF_FF80, 4'h0, 0);
        ls_op("lbu",    0, 3'b100, 32'h103, 0,            0, 32'h0000_0080, 4'h0, 0);
        ls_op("sh",     1, 3'b001, 32'h202, 32'h0000_BEEF, 0, 0, 4'b1100, 32'hBEEF_BEEF);
        ls_op("lh",     0, 3'b001, 32'h202, 0,            0, 32'hFFFF_BEEF, 4'h0, 0);
        ls_op("lhu",    0, 3'b101, 32'h202, 0,            0, 32'h0000_BEEF, 4'h0, 0);
        ls_op("lw_mis", 0, 3'b010, 32'h101, 0,            1, 0, 4'h0, 0);
        ls_op("sb",     1, 3'b000, 32'h101, 32'h0000_00A5, 0, 0, 4'b0010, 32'hA5A5_A5A5);
        ls_op("lw",     0, 3'b010, 32'h100, 0,            0, 32'h80FF_A512, 4'h0, 0);
        ls_op("sh_mis", 1, 3'b001, 32'h203, 32'h1234,     1, 0, 4'h0, 0);
        ls_op("f3_011", 0, 3'b011, 32'h102, 0,            1, 0, 4'h0, 0);
        ls_op("sw",     1, 3'b010, 32'h204, 32'hCAFE_F00D, 0, 0, 4'b1111, 32'hCAFE_F00D);
        ls_op("f3_111", 0, 3'b111, 32'h204, 0,            0, 32'hCAFE_F00D, 4'h0, 0);

        // Back-to-back fetch / load / fetch at full throughput.
        if_req = 1'b1; if_addr = 32'h10;
        next_cyc();
        if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_func3 = 3'b010; ls_addr = 32'h204;
        @(negedge clk);
        chk("b2b_if_valid", {31'b0, if_valid}, 1);
        chk("b2b_ls_gnt", {31'b0, ls_gnt}, 1);
        next_cyc();
        ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        chk("b2b_ls_rdata", ls_rdata, 32'hCAFE_F00D);
        chk("b2b_if_gnt", {31'b0, if_gnt}, 1);
        next_cyc();
        if_req = 1'b0;
        next_cyc();

        // Reset in the cycle after a fetch grant discards the return.
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        chk("rstmid_gnt", {31'b0, if_gnt}, 1);
        next_cyc();
        if_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstmid_if_valid", {31'b0, if_valid}, 0);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rstpost_if_valid", {31'b0, if_valid}, 0);
        next_cyc();
        if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        chk("rstpost_gnt", {31'b0, if_gnt}, 1);
        next_cyc();
        if_req = 1'b0;
        @(negedge clk);
        chk("rstpost_rdata", if_rdata, 32'h5555_AAAA);
        next_cyc();
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
